// File: rtl/score_overlay.sv
// ---------------------------------------------------------------------------
// score_overlay
//   Renders a binary score as decimal digits in a fixed window of a VGA frame.
//   A sequential double-dabble converter turns the captured score into BCD;
//   the result lands in a shadow register and is copied to the displayed
//   register only at frame start (pixel 0,0), so a frame never shows a mix of
//   old and new digits. Each digit is drawn from an 8x8 font, scaled up by
//   2**scale_log2_p in both directions.
//
// Ports
//   clk_i, reset_i     pixel clock, asynchronous active-high reset
//   x_i, y_i, xy_v_i   current pixel position and visible-area flag
//   score_i, score_v_i binary score and its one-cycle capture strobe
//   busy_o             converter is shifting or finishing
//   r_o, g_o, b_o      pixel colour, two cycles after x_i/y_i/xy_v_i
// ---------------------------------------------------------------------------
module score_overlay #(
    parameter int                     display_width_p  = 640,
    parameter int                     display_height_p = 480,
    parameter int                     bit_depth_p      = 8,
    parameter int                     digits_p         = 4,
    parameter int                     score_width_p    = 14,
    parameter int                     scale_log2_p     = 3,
    parameter int                     origin_x_p       = 0,
    parameter int                     origin_y_p       = 0,
    parameter logic [bit_depth_p-1:0] fg_r_p           = '1,
    parameter logic [bit_depth_p-1:0] fg_g_p           = '0,
    parameter logic [bit_depth_p-1:0] fg_b_p           = '0,
    parameter bit                     blank_lz_p       = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [$clog2(display_width_p)-1:0]    x_i,
    input  logic [$clog2(display_height_p)-1:0]   y_i,
    input  logic                                  xy_v_i,
    input  logic [score_width_p-1:0]              score_i,
    input  logic                                  score_v_i,
    output logic                                  busy_o,
    output logic [bit_depth_p-1:0]                r_o,
    output logic [bit_depth_p-1:0]                g_o,
    output logic [bit_depth_p-1:0]                b_o
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int x_width_lp     = $clog2(display_width_p);
    localparam int y_width_lp     = $clog2(display_height_p);
    localparam int bcd_width_lp   = 4 * digits_p;
    localparam int sr_width_lp    = bcd_width_lp + score_width_p;
    localparam int cnt_width_lp   = $clog2(score_width_p + 1);
    localparam int digit_width_lp = (digits_p > 1) ? $clog2(digits_p) : 1;
    localparam int glyph_px_lp    = 8 << scale_log2_p;
    localparam int win_w_lp       = digits_p * glyph_px_lp;

    localparam longint unsigned          limit_lp     = pow10(digits_p);
    localparam logic [score_width_p-1:0] sat_value_lp = score_width_p'(limit_lp - 1);
    localparam logic [cnt_width_lp-1:0]  last_cnt_lp  = cnt_width_lp'(score_width_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // One double-dabble step: correct every BCD nibble that would overflow
    // on doubling, then shift the whole register left.
    function automatic logic [sr_width_lp-1:0] dd_step(input logic [sr_width_lp-1:0] v);
        logic [sr_width_lp-1:0] t;
        t = v;
        for (int unsigned i = 0; i < digits_p; i++) begin
            if (t[score_width_p + 4*i +: 4] >= 4'd5) begin
                t[score_width_p + 4*i +: 4] = t[score_width_p + 4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    // 8x8 digit font, row 0 in the top byte, bit 7 is the leftmost column.
    function automatic logic [7:0] font_row(input logic [3:0] glyph, input logic [2:0] row);
        logic [63:0] bits;
        case (glyph)
            4'd0:    bits = 64'h3C666E7666663C00;
            4'd1:    bits = 64'h1838181818187E00;
            4'd2:    bits = 64'h3C66060C30607E00;
            4'd3:    bits = 64'h3C66061C06663C00;
            4'd4:    bits = 64'h0C1C3C6C7E0C0C00;
            4'd5:    bits = 64'h7E607C0606663C00;
            4'd6:    bits = 64'h3C66607C66663C00;
            4'd7:    bits = 64'h7E060C1830303000;
            4'd8:    bits = 64'h3C66663C66663C00;
            4'd9:    bits = 64'h3C66663E06663C00;
            default: bits = '0;
        endcase
        return bits[8*(7 - int'(row)) +: 8];
    endfunction

    state_t                     state;
    logic [cnt_width_lp-1:0]    shift_cnt;
    logic [sr_width_lp-1:0]     shift_reg;
    logic [bcd_width_lp-1:0]    shadow_bcd;
    logic [bcd_width_lp-1:0]    display_bcd;
    logic [score_width_p-1:0]   pend_val;
    logic                       pend_flag;
    logic [score_width_p-1:0]   sat_score;
    logic                       commit;

    assign sat_score = (64'(score_i) >= limit_lp) ? sat_value_lp : score_i;
    assign commit    = xy_v_i && (x_i == '0) && (y_i == '0);

    // Capture and conversion FSM.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            shift_cnt  <= '0;
            shift_reg  <= '0;
            shadow_bcd <= '0;
            pend_val   <= '0;
            pend_flag  <= 1'b0;
        end else begin
            if (score_v_i) begin
                pend_val  <= sat_score;
                pend_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    shift_cnt <= '0;
                    if (pend_flag) begin
                        shift_reg <= {{bcd_width_lp{1'b0}}, pend_val};
                        // A strobe arriving in this same cycle keeps the flag set.
                        if (!score_v_i) begin
                            pend_flag <= 1'b0;
                        end
                        busy_o <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= dd_step(shift_reg);
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == last_cnt_lp) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    shadow_bcd <= shift_reg[sr_width_lp-1 -: bcd_width_lp];
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Frame commit; reads the shadow before any same-cycle DONE write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            display_bcd <= '0;
        end else if (commit) begin
            display_bcd <= shadow_bcd;
        end
    end

    // Window decode and digit selection.
    logic signed [31:0]        ox;
    logic signed [31:0]        oy;
    logic                      inside_c;
    logic [digit_width_lp-1:0] digit_c;
    logic [2:0]                col_c;
    logic [2:0]                row_c;
    logic [3:0]                nib_c;
    logic                      blank_c;

    always_comb begin
        logic [3:0] dig;
        logic       lead;
        ox = $signed({{(32 - x_width_lp){1'b0}}, x_i}) - origin_x_p;
        oy = $signed({{(32 - y_width_lp){1'b0}}, y_i}) - origin_y_p;
        inside_c = (ox >= 0) && (ox < win_w_lp) && (oy >= 0) && (oy < glyph_px_lp);
        digit_c = '0;
        for (int unsigned i = 1; i < digits_p; i++) begin
            if (ox >= int'(i) * glyph_px_lp) begin
                digit_c = digit_width_lp'(i);
            end
        end
        col_c = ox[scale_log2_p +: 3];
        row_c = oy[scale_log2_p +: 3];
        // lead stays true while every digit so far (MS first) is zero.
        nib_c   = '0;
        blank_c = 1'b0;
        lead    = blank_lz_p;
        for (int unsigned i = 0; i < digits_p; i++) begin
            dig  = display_bcd[4*(digits_p - 1 - i) +: 4];
            lead = lead && (dig == 4'd0) && (i != digits_p - 1);
            if (digit_c == digit_width_lp'(i)) begin
                nib_c   = dig;
                blank_c = lead;
            end
        end
    end

    // Pixel pipeline: stage 1 holds the ROM address and qualifiers,
    // stage 2 is the colour register fed by the ROM row.
    logic       s1_inside;
    logic       s1_valid;
    logic       s1_blank;
    logic [2:0] s1_col;
    logic [6:0] s1_addr;
    logic [7:0] rom_row;
    logic       lit;

    assign rom_row = font_row(s1_addr[6:3], s1_addr[2:0]);
    assign lit     = s1_inside && s1_valid && !s1_blank && rom_row[3'd7 - s1_col];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_inside <= 1'b0;
            s1_valid  <= 1'b0;
            s1_blank  <= 1'b0;
            s1_col    <= '0;
            s1_addr   <= '0;
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
        end else begin
            s1_inside <= inside_c;
            s1_valid  <= xy_v_i;
            s1_blank  <= blank_c;
            s1_col    <= col_c;
            s1_addr   <= {nib_c, row_c};
            r_o       <= lit ? fg_r_p : '0;
            g_o       <= lit ? fg_g_p : '0;
            b_o       <= lit ? fg_b_p : '0;
        end
    end

endmodule

// File: tb/tb_score_overlay.sv
module tb_score_overlay;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic       v;
    logic [13:0] score;
    logic       sv;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    score_overlay #(.blank_lz_p(1'b0)) dut (
        .clk_i(clk), .reset_i(reset), .x_i(x), .y_i(y), .xy_v_i(v),
        .score_i(score), .score_v_i(sv), .busy_o(busy0),
        .r_o(r0), .g_o(g0), .b_o(b0)
    );

    score_overlay #(.origin_x_p(100), .origin_y_p(50), .blank_lz_p(1'b1)) dut_lz (
        .clk_i(clk), .reset_i(reset), .x_i(x), .y_i(y), .xy_v_i(v),
        .score_i(score), .score_v_i(sv), .busy_o(busy1),
        .r_o(r1), .g_o(g1), .b_o(b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int val);
        score = 14'(val);
        sv = 1'b1;
        tick(1);
        sv = 1'b0;
    endtask

    task automatic commit();
        x = '0; y = '0; v = 1'b1;
        tick(1);
        v = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy0 !== lvl && n < 100) begin
            tick(1);
            n++;
        end
        check(tag, 32'(busy0), 32'(lvl));
    endtask

    task automatic convert(input int val);
        strobe(val);
        wait_busy(1'b1, "busy_rise");
        wait_busy(1'b0, "busy_fall");
    endtask

    task automatic probe(input int inst, input int px, input int py, output logic [7:0] r);
        x = 10'(px); y = 9'(py); v = 1'b1;
        tick(2);
        r = (inst != 0) ? r1 : r0;
    endtask

    // Rows 0 and 3 of each glyph form a unique 16-bit signature.
    function automatic logic [3:0] decode(input logic [15:0] sig);
        case (sig)
            16'h3C76: return 4'h0;
            16'h1818: return 4'h1;
            16'h3C0C: return 4'h2;
            16'h3C1C: return 4'h3;
            16'h0C6C: return 4'h4;
            16'h7E06: return 4'h5;
            16'h3C7C: return 4'h6;
            16'h7E18: return 4'h7;
            16'h3C3C: return 4'h8;
            16'h3C3E: return 4'h9;
            16'h0000: return 4'hB;
            default:  return 4'hF;
        endcase
    endfunction

    task automatic read_disp(input int inst, output logic [15:0] val);
        int ox0 = (inst != 0) ? 100 : 0;
        int oy0 = (inst != 0) ? 50 : 0;
        logic [15:0] sig;
        logic [7:0]  px;
        val = '0;
        for (int d = 0; d < 4; d++) begin
            sig = '0;
            for (int rs = 0; rs < 2; rs++) begin
                for (int c = 0; c < 8; c++) begin
                    probe(inst, ox0 + d*64 + c*8 + 4, oy0 + rs*24 + 4, px);
                    sig[(rs == 0 ? 15 : 7) - c] = (px != 0);
                end
            end
            val[15 - 4*d -: 4] = decode(sig);
        end
        v = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] disp;
        logic [7:0]  px;
        int n;
        int seen;

        reset = 1'b1; x = '0; y = '0; v = 1'b0; score = '0; sv = 1'b0;
        tick(3);
        check("rst_r", 32'(r0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        reset = 1'b0;
        tick(1);
        read_disp(0, disp);
        check("rst_disp", 32'(disp), 32'h0000);

        // Conversion latency and no-tear behaviour.
        strobe(1234);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy0) n++;
            else if (n > 0) break;
        end
        check("busy_cycles", n, 15);
        read_disp(0, disp);
        check("pre_commit", 32'(disp), 32'h0000);
        commit();
        read_disp(0, disp);
        check("disp_1234", 32'(disp), 32'h1234);
        read_disp(1, disp);
        check("lz_1234", 32'(disp), 32'h1234);

        // Pixel timing with "1000".
        convert(1000);
        commit();
        probe(0, 0, 0, px);
        check("px_0_0", 32'(px), 32'h00);
        x = 10'd24; y = 9'd0; v = 1'b1;
        tick(1);
        check("lat_1cyc", 32'(r0), 32'h00);
        tick(1);
        check("lat_2cyc", 32'(r0), 32'hFF);
        check("lat_g", 32'(g0), 32'h00);
        check("lat_b", 32'(b0), 32'h00);
        probe(0, 639, 0, px);
        check("px_right_edge", 32'(px), 32'h00);
        probe(0, 24, 64, px);
        check("px_below", 32'(px), 32'h00);
        x = 10'd24; y = 9'd0; v = 1'b0;
        tick(2);
        check("px_not_valid", 32'(r0), 32'h00);
        probe(1, 124, 50, px);
        check("lz_px_lit", 32'(px), 32'hFF);
        probe(1, 124, 49, px);
        check("lz_px_above", 32'(px), 32'h00);
        probe(1, 99, 54, px);
        check("lz_px_left", 32'(px), 32'h00);
        v = 1'b0;

        // Saturation.
        convert(12000);
        commit();
        read_disp(0, disp);
        check("sat_9999", 32'(disp), 32'h9999);

        // Last strobe wins while busy.
        strobe(5);
        tick(3);
        check("busy_mid", 32'(busy0), 32'h1);
        strobe(7);
        wait_busy(1'b0, "first_done");
        commit();
        read_disp(0, disp);
        check("first_5", 32'(disp), 32'h0005);
        wait_busy(1'b0, "second_done");
        commit();
        read_disp(0, disp);
        check("second_7", 32'(disp), 32'h0007);

        // Asynchronous reset in the middle of a conversion.
        x = 10'd204; y = 9'd4; v = 1'b1;
        tick(2);
        strobe(4321);
        tick(4);
        check("pre_rst_r", 32'(r0), 32'hFF);
        check("pre_rst_busy", 32'(busy0), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_busy", 32'(busy0), 32'h0);
        check("async_r", 32'(r0), 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        v = 1'b0;
        seen = 0;
        repeat (20) begin
            tick(1);
            if (busy0) seen = 1;
        end
        check("no_resume", seen, 0);
        commit();
        read_disp(0, disp);
        check("post_rst", 32'(disp), 32'h0000);

        // DONE and frame commit in the same cycle.
        strobe(1234);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy0) n++;
            if (n == 15) break;
        end
        check("reach_done", n, 15);
        x = '0; y = '0; v = 1'b1;
        tick(1);
        v = 1'b0;
        check("done_exit", 32'(busy0), 32'h0);
        read_disp(0, disp);
        check("collide_old", 32'(disp), 32'h0000);
        commit();
        read_disp(0, disp);
        check("collide_new", 32'(disp), 32'h1234);

        // Leading-zero blanking.
        convert(42);
        commit();
        read_disp(0, disp);
        check("plain_42", 32'(disp), 32'h0042);
        read_disp(1, disp);
        check("lz_42", 32'(disp), 32'hBB42);
        convert(0);
        commit();
        read_disp(1, disp);
        check("lz_0", 32'(disp), 32'hBBB0);
        convert(402);
        commit();
        read_disp(1, disp);
        check("lz_402", 32'(disp), 32'hB402);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
